rtc_clock_core: RTL and testbench

//   Parametrised time-of-day core. Successor to the fixed 1-tick-per-second digital_clock.

---
 rtl/rtc_clock_core_if.sv | 37 +++
 rtl/rtc_clock_core.sv | 125 ++++++++++++
 tb/tb_rtc_clock_core.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_clock_core_if.sv
// Control, set/alarm inputs and time/status outputs of rtc_clock_core.
// The master drives controls and reads time; the slave is the core itself.
interface rtc_clock_core_if;
  logic       run;
  logic       mode_12h;
  logic       set_en;
  logic [4:0] set_h;
  logic [5:0] set_m;
  logic [5:0] set_s;
  logic       alarm_en;
  logic [4:0] alarm_h;
  logic [5:0] alarm_m;
  logic       alarm_clr;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic [4:0] disp_hours;
  logic       pm;
  logic       sec_tick;
  logic       day_wrap;
  logic       set_err;
  logic       alarm_flag;

  modport master (
    output run, mode_12h, set_en, set_h, set_m, set_s,
           alarm_en, alarm_h, alarm_m, alarm_clr,
    input  seconds, minutes, hours, disp_hours, pm,
           sec_tick, day_wrap, set_err, alarm_flag
  );

  modport slave (
    input  run, mode_12h, set_en, set_h, set_m, set_s,
           alarm_en, alarm_h, alarm_m, alarm_clr,
    output seconds, minutes, hours, disp_hours, pm,
           sec_tick, day_wrap, set_err, alarm_flag
  );
endinterface

// File: rtl/rtc_clock_core.sv
// Time-of-day core: prescaled seconds counter with validated load,
// 12h/24h display conversion and a sticky alarm flag.
module rtc_clock_core #(
  parameter int TICKS_PER_SEC = 2,
  parameter int PS_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rtc_clock_core_if.slave  bus
);

  logic [PS_W-1:0] ps_q, ps_d;
  logic [5:0]      sec_q, sec_d;
  logic [5:0]      min_q, min_d;
  logic [4:0]      hr_q, hr_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;
  logic            err_q, err_d;
  logic            alarm_q, alarm_d;

  logic            tc;
  logic            load_ok;
  logic            advance;
  logic            carry_s, carry_m, carry_h;
  logic [5:0]      sec_inc, min_inc;
  logic [4:0]      hr_inc;
  logic            alarm_hit;
  logic [4:0]      disp_hr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q    <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      alarm_q <= alarm_d;
    end
  end

  // A rejected load is ignored entirely, so counting carries on as if set_en were low.
  always_comb begin
    tc      = bus.run && (ps_q == PS_W'(TICKS_PER_SEC - 1));
    load_ok = bus.set_en && (bus.set_h <= 5'd23) && (bus.set_m <= 6'd59)
              && (bus.set_s <= 6'd59);
    advance = tc && !load_ok;

    carry_s = (sec_q == 6'd59);
    carry_m = carry_s && (min_q == 6'd59);
    carry_h = carry_m && (hr_q == 5'd23);
    sec_inc = carry_s ? 6'd0 : sec_q + 6'd1;
    min_inc = carry_s ? (carry_m ? 6'd0 : min_q + 6'd1) : min_q;
    hr_inc  = carry_m ? (carry_h ? 5'd0 : hr_q + 5'd1) : hr_q;

    alarm_hit = advance && bus.alarm_en && (hr_inc == bus.alarm_h)
                && (min_inc == bus.alarm_m) && (sec_inc == 6'd0);
  end

  always_comb begin
    ps_d    = ps_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    tick_d  = advance;
    wrap_d  = advance && carry_h;
    err_d   = bus.set_en && !load_ok;
    alarm_d = alarm_q;

    if (load_ok) begin
      ps_d  = '0;
      sec_d = bus.set_s;
      min_d = bus.set_m;
      hr_d  = bus.set_h;
    end else if (bus.run) begin
      if (tc) begin
        ps_d  = '0;
        sec_d = sec_inc;
        min_d = min_inc;
        hr_d  = hr_inc;
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end

    // Set has priority over a simultaneous clear.
    if (alarm_hit) begin
      alarm_d = 1'b1;
    end else if (bus.alarm_clr) begin
      alarm_d = 1'b0;
    end
  end

  always_comb begin
    disp_hr = hr_q;
    if (bus.mode_12h) begin
      if (hr_q == 5'd0) begin
        disp_hr = 5'd12;
      end else if (hr_q > 5'd12) begin
        disp_hr = hr_q - 5'd12;
      end
    end
  end

  assign bus.seconds    = sec_q;
  assign bus.minutes    = min_q;
  assign bus.hours      = hr_q;
  assign bus.disp_hours = disp_hr;
  assign bus.pm         = (hr_q >= 5'd12);
  assign bus.sec_tick   = tick_q;
  assign bus.day_wrap   = wrap_q;
  assign bus.set_err    = err_q;
  assign bus.alarm_flag = alarm_q;

endmodule

// File: tb/tb_rtc_clock_core.sv
// Directed plus randomized checks of rtc_clock_core against a seconds-of-day
// reference model.
module tb_rtc_clock_core;
  localparam int T = 2;

  logic clk;
  logic rst_n;
  rtc_clock_core_if bus ();

  rtc_clock_core #(.TICKS_PER_SEC(T), .PS_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int tod;
  int ps;
  bit m_tick, m_wrap, m_err, m_alarm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    tod = 0; ps = 0;
    m_tick = 0; m_wrap = 0; m_err = 0; m_alarm = 0;
  endtask

  task automatic model_edge();
    bit valid, hit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    valid  = (int'(bus.set_h) <= 23) && (int'(bus.set_m) <= 59) && (int'(bus.set_s) <= 59);
    hit    = 0;
    m_tick = 0;
    m_wrap = 0;
    m_err  = bus.set_en && !valid;
    if (bus.set_en && valid) begin
      tod = int'(bus.set_h) * 3600 + int'(bus.set_m) * 60 + int'(bus.set_s);
      ps  = 0;
    end else if (bus.run) begin
      if (ps == T - 1) begin
        ps     = 0;
        tod    = (tod + 1) % 86400;
        m_tick = 1;
        m_wrap = (tod == 0);
        hit    = bus.alarm_en && (tod == int'(bus.alarm_h) * 3600 + int'(bus.alarm_m) * 60);
      end else begin
        ps++;
      end
    end
    if (hit) m_alarm = 1;
    else if (bus.alarm_clr) m_alarm = 0;
  endtask

  task automatic check_all(input string tag);
    int h, dh;
    h  = tod / 3600;
    dh = h;
    if (bus.mode_12h) dh = (h % 12 == 0) ? 12 : h % 12;
    chk({tag, ".sec"},   32'(bus.seconds),    32'(tod % 60));
    chk({tag, ".min"},   32'(bus.minutes),    32'((tod / 60) % 60));
    chk({tag, ".hr"},    32'(bus.hours),      32'(h));
    chk({tag, ".disp"},  32'(bus.disp_hours), 32'(dh));
    chk({tag, ".pm"},    32'(bus.pm),         32'(h >= 12));
    chk({tag, ".tick"},  32'(bus.sec_tick),   32'(m_tick));
    chk({tag, ".wrap"},  32'(bus.day_wrap),   32'(m_wrap));
    chk({tag, ".err"},   32'(bus.set_err),    32'(m_err));
    chk({tag, ".alarm"}, 32'(bus.alarm_flag), 32'(m_alarm));
  endtask

  // One clock: model follows the edge, outputs checked 1 ns later, return at negedge.
  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
    bus.set_en    = 1'b0;
    bus.alarm_clr = 1'b0;
  endtask

  task automatic load(input int h, input int m, input int s, input string tag);
    bus.set_en = 1'b1;
    bus.set_h  = 5'(h);
    bus.set_m  = 6'(m);
    bus.set_s  = 6'(s);
    cyc(tag);
  endtask

  initial begin
    int tgt, wraps;
    rst_n         = 1'b0;
    bus.run       = 1'b0;
    bus.mode_12h  = 1'b0;
    bus.set_en    = 1'b0;
    bus.set_h     = '0;
    bus.set_m     = '0;
    bus.set_s     = '0;
    bus.alarm_en  = 1'b0;
    bus.alarm_h   = '0;
    bus.alarm_m   = '0;
    bus.alarm_clr = 1'b0;
    model_reset();
    wraps = 0;

    @(negedge clk);
    cyc("reset");
    bus.mode_12h = 1'b1;
    #1 check_all("reset12h");
    bus.mode_12h = 1'b0;

    // Count from reset
    rst_n   = 1'b1;
    bus.run = 1'b1;
    for (int i = 0; i < 6; i++) cyc("count");

    // Day wrap
    load(23, 59, 58, "ld_wrap");
    for (int i = 0; i < 4; i++) begin
      cyc("wrap");
      if (bus.day_wrap) wraps++;
    end
    chk("wrap_once", 32'(wraps), 32'd1);

    // Rejected loads while frozen
    bus.run = 1'b0;
    load(24, 0, 0, "bad_h");
    cyc("bad_h_after");
    load(5, 60, 0, "bad_m");
    cyc("bad_m_after");
    load(5, 5, 60, "bad_s");
    cyc("bad_s_after");

    // Load on a terminal-count cycle wins over the advance
    bus.run = 1'b1;
    for (int i = 0; i < 4 && ps != T - 1; i++) cyc("align");
    chk("tc_aligned", 32'(ps), 32'(T - 1));
    load(10, 20, 30, "ld_tc");
    chk("ld_tc_sec", 32'(bus.seconds), 32'd30);
    for (int i = 0; i < 3; i++) cyc("after_tc");

    // 12h display
    bus.run      = 1'b0;
    bus.mode_12h = 1'b1;
    load(0, 0, 0, "d0");
    chk("d0_disp", 32'(bus.disp_hours), 32'd12);
    load(12, 0, 0, "d12");
    chk("d12_pm", 32'(bus.pm), 32'd1);
    load(13, 5, 0, "d13");
    chk("d13_disp", 32'(bus.disp_hours), 32'd1);
    bus.mode_12h = 1'b0;
    #1 check_all("d13_24h");

    // Alarm
    bus.alarm_en = 1'b1;
    bus.alarm_h  = 5'd7;
    bus.alarm_m  = 6'd30;
    load(7, 29, 59, "al_ld");
    bus.run = 1'b1;
    for (int i = 0; i < 6; i++) cyc("al_run");
    chk("al_set", 32'(bus.alarm_flag), 32'd1);
    bus.alarm_en = 1'b0;
    cyc("al_hold");
    bus.alarm_clr = 1'b1;
    cyc("al_clr");
    bus.alarm_en = 1'b1;
    bus.run      = 1'b0;
    load(7, 30, 0, "al_ld_on");
    cyc("al_ld_after");
    chk("al_ld_noset", 32'(bus.alarm_flag), 32'd0);

    // Freeze then async reset mid-count
    bus.run = 1'b1;
    cyc("pre_freeze");
    bus.run = 1'b0;
    for (int i = 0; i < 10; i++) cyc("frozen");
    bus.run = 1'b1;
    for (int i = 0; i < 3; i++) cyc("resume");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc("post_rst");

    // Randomized operation
    for (int n = 0; n < 3000; n++) begin
      bus.run       = ($urandom_range(0, 9) != 0);
      bus.mode_12h  = 1'($urandom_range(0, 1));
      bus.alarm_en  = ($urandom_range(0, 7) != 0);
      bus.alarm_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) begin
        tgt = (tod + 60 * $urandom_range(0, 2)) % 86400;
        bus.alarm_h = 5'(tgt / 3600);
        bus.alarm_m = 6'((tgt / 60) % 60);
      end
      if ($urandom_range(0, 49) == 0) begin
        tgt = ($urandom_range(0, 1) != 0) ? $urandom_range(86380, 86399) : $urandom_range(0, 86399);
        bus.set_en = 1'b1;
        bus.set_h  = 5'(tgt / 3600);
        bus.set_m  = 6'((tgt / 60) % 60);
        bus.set_s  = 6'(tgt % 60);
      end else if (!bus.run && $urandom_range(0, 9) == 0) begin
        bus.set_en = 1'b1;
        bus.set_h  = 5'($urandom_range(0, 31));
        bus.set_m  = 6'($urandom_range(0, 63));
        bus.set_s  = 6'($urandom_range(0, 63));
      end
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
